// File: rtl/traffic_pkg.sv
// Purpose : shared types and constants for the multi-phase traffic controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

    // Per-phase controller states.
    typedef enum logic [2:0] {
        ST_GREEN   = 3'd0,
        ST_EXT     = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_ALL_RED = 3'd3,
        ST_WALK    = 3'd4
    } state_t;

    // prog_sel codes selecting which timing-table entry a write targets.
    localparam logic [1:0] SEL_GREEN  = 2'd0;
    localparam logic [1:0] SEL_EXT    = 2'd1;
    localparam logic [1:0] SEL_YELLOW = 2'd2;
    localparam logic [1:0] SEL_WALK   = 2'd3;

    // Fixed all-red clearance, in ticks.
    localparam int ALL_RED_TICKS = 1;

    // Timing-table contents after reset, in ticks.
    localparam int DEF_GREEN  = 6;
    localparam int DEF_EXT    = 3;
    localparam int DEF_YELLOW = 2;
    localparam int DEF_WALK   = 3;

    // Round-robin successor of a phase index, wrapping at num_ph.
    function automatic logic [2:0] ph_inc(input logic [2:0] ph, input int num_ph);
        if (int'(ph) >= num_ph - 1)
            return 3'd0;
        return ph + 3'd1;
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Purpose : one-second tick divider; tick is high one cycle in every DIV_CYC clocks.
// Latency : first tick DIV_CYC clocks after reset release or a clear.
// Backpressure: none; free-running.
// Ports   : clk, rst (sync, active-low), i_clr (restart count), tick (1-cycle pulse).
module traffic_tick_gen #(
    parameter int DIV_CYC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic tick
);

    localparam int CNT_W = (DIV_CYC > 2) ? $clog2(DIV_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Purpose : multi-phase traffic signal controller with vehicle extension, pedestrian walk
//           and a runtime-programmable timing table.
// Latency : lamps decode combinationally from registered state; a reprogram strobe
//           restarts phase 0 green on the next clock.
// Backpressure: none; inputs are sampled every clock and never stalled.
// Ports   : clk, rst (sync, active-low), sensor/walk_req (per phase), reprogram,
//           prog_phase/prog_sel/prog_value (table write), green/yellow/red/walk (per
//           phase lamps), cur_phase (phase being served).
// Option  : define TRAFFIC_DEMAND_SKIP_EN to skip phases with no vehicle or walk demand.
module multi_phase_traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PH  = 2,
    parameter int TIME_W  = 4,
    parameter int DIV_CYC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PH-1:0] sensor,
    input  logic [NUM_PH-1:0] walk_req,
    input  logic              reprogram,
    input  logic [2:0]        prog_phase,
    input  logic [1:0]        prog_sel,
    input  logic [TIME_W-1:0] prog_value,
    output logic [NUM_PH-1:0] green,
    output logic [NUM_PH-1:0] yellow,
    output logic [NUM_PH-1:0] red,
    output logic [NUM_PH-1:0] walk,
    output logic [2:0]        cur_phase
);

    // Timing table, sized for the maximum of 8 phases so a 3-bit index is always exact.
    logic [TIME_W-1:0] r_green_t [0:7];
    logic [TIME_W-1:0] r_ext_t   [0:7];
    logic [TIME_W-1:0] r_yel_t   [0:7];
    logic [TIME_W-1:0] r_walk_t  [0:7];

    state_t            r_state;
    logic [2:0]        r_phase;
    logic [TIME_W-1:0] r_timer;
    logic [7:0]        r_pend;

    logic              w_tick;
    logic [7:0]        w_sensor8;
    logic [7:0]        w_walk8;
    logic              w_wr_ok;
    logic              w_expire;
    logic              w_load;
    state_t            w_nstate;
    logic [2:0]        w_nphase;
    logic [2:0]        w_next_ph;
    logic [TIME_W-1:0] w_raw;
    logic [TIME_W-1:0] w_dur;
    logic [TIME_W-1:0] w_rst_raw;
    logic [TIME_W-1:0] w_rst_dur;
    logic [7:0]        w_pend_clr;

    traffic_tick_gen #(
        .DIV_CYC (DIV_CYC)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .i_clr (reprogram),
        .tick  (w_tick)
    );

    assign w_sensor8 = 8'(sensor);
    assign w_walk8   = 8'(walk_req);
    // Out-of-range writes are dropped, but the strobe still restarts the cycle.
    assign w_wr_ok   = reprogram && ({1'b0, prog_phase} < 4'(NUM_PH));

    // Phase that follows the current one when leaving ALL_RED/WALK.
    always_comb begin
        w_next_ph = ph_inc(r_phase, NUM_PH);
`ifdef TRAFFIC_DEMAND_SKIP_EN
        begin : g_skip
            logic       w_found;
            logic [2:0] w_cand;
            w_found = 1'b0;
            w_cand  = ph_inc(r_phase, NUM_PH);
            // First successor with demand wins; with none, the plain successor is kept.
            for (int k = 1; k < NUM_PH; k++) begin
                if (!w_found && (w_sensor8[w_cand] || r_pend[w_cand])) begin
                    w_found   = 1'b1;
                    w_next_ph = w_cand;
                end
                w_cand = ph_inc(w_cand, NUM_PH);
            end
        end
`else
        // Strict round-robin: every phase is served in turn.
`endif
    end

    // Next-state logic: transitions only on the tick where the timer reads 1.
    always_comb begin
        w_nstate = r_state;
        w_nphase = r_phase;
        w_expire = w_tick && (r_timer == TIME_W'(1));
        w_load   = w_expire;
        if (w_expire) begin
            case (r_state)
                ST_GREEN:   w_nstate = w_sensor8[r_phase] ? ST_EXT : ST_YELLOW;
                ST_EXT:     w_nstate = ST_YELLOW;
                ST_YELLOW:  w_nstate = ST_ALL_RED;
                ST_ALL_RED: begin
                    if (r_pend[r_phase]) begin
                        w_nstate = ST_WALK;
                    end else begin
                        w_nstate = ST_GREEN;
                        w_nphase = w_next_ph;
                    end
                end
                ST_WALK: begin
                    w_nstate = ST_GREEN;
                    w_nphase = w_next_ph;
                end
                default: begin
                    w_nstate = ST_GREEN;
                    w_nphase = 3'd0;
                end
            endcase
        end
    end

    // Duration loaded on entry to the next state; zero means one tick.
    always_comb begin
        case (w_nstate)
            ST_GREEN:   w_raw = r_green_t[w_nphase];
            ST_EXT:     w_raw = r_ext_t[r_phase];
            ST_YELLOW:  w_raw = r_yel_t[r_phase];
            ST_ALL_RED: w_raw = TIME_W'(ALL_RED_TICKS);
            ST_WALK:    w_raw = r_walk_t[r_phase];
            default:    w_raw = TIME_W'(1);
        endcase
        w_dur = (w_raw == '0) ? TIME_W'(1) : w_raw;

        // A restart that also rewrites phase 0 green must use the new value at once.
        if (w_wr_ok && (prog_phase == 3'd0) && (prog_sel == SEL_GREEN))
            w_rst_raw = prog_value;
        else
            w_rst_raw = r_green_t[0];
        w_rst_dur = (w_rst_raw == '0) ? TIME_W'(1) : w_rst_raw;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_GREEN;
            r_phase <= 3'd0;
            r_timer <= TIME_W'(DEF_GREEN);
        end else if (reprogram) begin
            r_state <= ST_GREEN;
            r_phase <= 3'd0;
            r_timer <= w_rst_dur;
        end else if (w_load) begin
            r_state <= w_nstate;
            r_phase <= w_nphase;
            r_timer <= w_dur;
        end else if (w_tick) begin
            r_timer <= r_timer - TIME_W'(1);
        end
    end

    // Pending walk requests: a new request on the clearing cycle survives.
    assign w_pend_clr = (w_load && !reprogram && (w_nstate == ST_WALK)) ?
                        (8'd1 << r_phase) : 8'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= 8'd0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_walk8;
        end
    end

    // Timing table writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_green_t[i] <= TIME_W'(DEF_GREEN);
                r_ext_t[i]   <= TIME_W'(DEF_EXT);
                r_yel_t[i]   <= TIME_W'(DEF_YELLOW);
                r_walk_t[i]  <= TIME_W'(DEF_WALK);
            end
        end else if (w_wr_ok) begin
            case (prog_sel)
                SEL_GREEN:  r_green_t[prog_phase] <= prog_value;
                SEL_EXT:    r_ext_t[prog_phase]   <= prog_value;
                SEL_YELLOW: r_yel_t[prog_phase]   <= prog_value;
                SEL_WALK:   r_walk_t[prog_phase]  <= prog_value;
                default:    r_green_t[prog_phase] <= prog_value;
            endcase
        end
    end

    // Lamp decode; while reset is asserted the reset pattern is forced so no stale
    // state can show.
    always_comb begin
        green     = '0;
        yellow    = '0;
        walk      = '0;
        cur_phase = 3'd0;
        if (!rst) begin
            green = NUM_PH'(1);
        end else begin
            cur_phase = r_phase;
            case (r_state)
                ST_GREEN, ST_EXT: green  = NUM_PH'(1) << r_phase;
                ST_YELLOW:        yellow = NUM_PH'(1) << r_phase;
                ST_WALK:          walk   = NUM_PH'(1) << r_phase;
                default:          green  = '0;
            endcase
        end
        red = ~(green | yellow);
    end

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Purpose : self-checking bench for multi_phase_traffic_ctrl (DIV_CYC=4 so one tick = 4 clocks).
// Latency : n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_multi_phase_traffic_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-phase instance
    logic       rst;
    logic [1:0] sensor, walk_req;
    logic       reprogram;
    logic [2:0] prog_phase;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
    logic [1:0] green, yellow, red, walk;
    logic [2:0] cur_phase;

    // 4-phase instance
    logic       rst4;
    logic [3:0] sensor4, walk_req4;
    logic       reprogram4;
    logic [2:0] prog_phase4;
    logic [1:0] prog_sel4;
    logic [3:0] prog_value4;
    logic [3:0] green4, yellow4, red4, walk4;
    logic [2:0] cur_phase4;

    multi_phase_traffic_ctrl #(.NUM_PH(2), .TIME_W(4), .DIV_CYC(4)) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .walk_req(walk_req),
        .reprogram(reprogram), .prog_phase(prog_phase), .prog_sel(prog_sel),
        .prog_value(prog_value), .green(green), .yellow(yellow), .red(red),
        .walk(walk), .cur_phase(cur_phase)
    );

    multi_phase_traffic_ctrl #(.NUM_PH(4), .TIME_W(4), .DIV_CYC(4)) dut4 (
        .clk(clk), .rst(rst4), .sensor(sensor4), .walk_req(walk_req4),
        .reprogram(reprogram4), .prog_phase(prog_phase4), .prog_sel(prog_sel4),
        .prog_value(prog_value4), .green(green4), .yellow(yellow4), .red(red4),
        .walk(walk4), .cur_phase(cur_phase4)
    );

    // One expected lamp segment: constant outputs held for len clocks.
    typedef struct {
        logic [1:0] g;
        logic [1:0] y;
        logic [1:0] w;
        logic [2:0] ph;
        int         len;
    } seg_t;

    typedef struct {
        logic [1:0] sens;
        logic [1:0] wreq;
        int         first;
        int         count;
    } scen_t;

    seg_t  exp_q[$];
    seg_t  tbl[$];
    scen_t sc[3];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    seg_no = 0;
    bit    mon_en = 1'b0;

    function automatic logic [1:0] oh(input int ph);
        return (ph == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic seg_t mk(input logic [1:0] g, input logic [1:0] y,
                                input logic [1:0] w, input int ph, input int len);
        seg_t s;
        s.g = g; s.y = y; s.w = w; s.ph = 3'(ph); s.len = len;
        return s;
    endfunction

    function automatic seg_t sG(input int ph, input int len);
        return mk(oh(ph), 2'b00, 2'b00, ph, len);
    endfunction
    function automatic seg_t sY(input int ph, input int len);
        return mk(2'b00, oh(ph), 2'b00, ph, len);
    endfunction
    function automatic seg_t sAR(input int ph);
        return mk(2'b00, 2'b00, 2'b00, ph, 4);
    endfunction
    function automatic seg_t sW(input int ph, input int len);
        return mk(2'b00, 2'b00, oh(ph), ph, len);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic close_seg(input logic [10:0] s, input int len);
        seg_t       e;
        logic [1:0] req_r;
        if (exp_q.size() == 0) return;
        e     = exp_q.pop_front();
        req_r = ~(e.g | e.y);
        n_cmp++;
        if (s[10:9] !== e.g || s[8:7] !== e.y || s[6:5] !== req_r || s[4:3] !== e.w ||
            s[2:0] !== e.ph || len != e.len) begin
            n_bad++;
            $display("FAIL seg%0d: got g=%b y=%b r=%b w=%b ph=%0d len=%0d, required g=%b y=%b r=%b w=%b ph=%0d len=%0d",
                     seg_no, s[10:9], s[8:7], s[6:5], s[4:3], s[2:0], len,
                     e.g, e.y, req_r, e.w, e.ph, e.len);
        end
        seg_no++;
    endtask

    // Segment monitor: samples on the falling edge and closes a segment on each change.
    task automatic monitor();
        logic [10:0] prev;
        logic [10:0] s;
        int          run;
        bit          have;
        have = 1'b0;
        run  = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                have = 1'b0;
            end else begin
                s = {green, yellow, red, walk, cur_phase};
                if (have && s == prev) begin
                    run++;
                end else begin
                    if (have) close_seg(prev, run);
                    prev = s;
                    run  = 1;
                    have = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds reset for 3 clocks and releases it 1ns after a rising edge.
    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b0; sensor = '0; walk_req = '0; reprogram = 1'b0;
        prog_phase = '0; prog_sel = '0; prog_value = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: %0d segments outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic prog(input logic [2:0] ph, input logic [1:0] sel, input logic [3:0] val);
        reprogram = 1'b1; prog_phase = ph; prog_sel = sel; prog_value = val;
        step(1);
        reprogram = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sensor = '0; walk_req = '0; reprogram = 1'b0;
        prog_phase = '0; prog_sel = '0; prog_value = '0;
        rst4 = 1'b0; sensor4 = '0; walk_req4 = '0; reprogram4 = 1'b0;
        prog_phase4 = '0; prog_sel4 = '0; prog_value4 = '0;
        fork
            monitor();
        join_none

        // Expected segment table: idle cycle, vehicle extension, walk after phase 1.
        tbl.push_back(sG(0, 24)); tbl.push_back(sY(0, 8)); tbl.push_back(sAR(0));
        tbl.push_back(sG(1, 24)); tbl.push_back(sY(1, 8)); tbl.push_back(sAR(1));
        tbl.push_back(sG(0, 36)); tbl.push_back(sY(0, 8)); tbl.push_back(sAR(0));
        tbl.push_back(sG(1, 24));
        tbl.push_back(sG(0, 24)); tbl.push_back(sY(0, 8)); tbl.push_back(sAR(0));
        tbl.push_back(sG(1, 24)); tbl.push_back(sY(1, 8)); tbl.push_back(sAR(1));
        tbl.push_back(sW(1, 12));
        tbl.push_back(sG(0, 24)); tbl.push_back(sY(0, 8)); tbl.push_back(sAR(0));
        tbl.push_back(sG(1, 24)); tbl.push_back(sY(1, 8)); tbl.push_back(sAR(1));
        sc[0] = '{2'b00, 2'b00, 0, 6};
        sc[1] = '{2'b01, 2'b00, 6, 4};
        sc[2] = '{2'b00, 2'b10, 10, 13};

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_green",  32'(green),     32'h1);
        chk("rst_yellow", 32'(yellow),    32'h0);
        chk("rst_red",    32'(red),       32'h2);
        chk("rst_walk",   32'(walk),      32'h0);
        chk("rst_phase",  32'(cur_phase), 32'h0);
        chk("rst4_red",   32'(red4),      32'hE);

        // Table-driven scenarios.
        for (int i = 0; i < 3; i++) begin
            do_reset();
            sensor = sc[i].sens;
            for (int j = 0; j < sc[i].count; j++)
                exp_q.push_back(tbl[sc[i].first + j]);
            step(10);
            walk_req = sc[i].wreq;
            step(1);
            walk_req = 2'b00;
            wait_drain($sformatf("scen%0d", i), 600);
        end

        // Walk request on the very cycle its pending bit clears is kept.
        do_reset();
        exp_q.push_back(sG(0, 24)); exp_q.push_back(sY(0, 8)); exp_q.push_back(sAR(0));
        exp_q.push_back(sG(1, 24)); exp_q.push_back(sY(1, 8)); exp_q.push_back(sAR(1));
        exp_q.push_back(sW(1, 12));
        exp_q.push_back(sG(0, 24)); exp_q.push_back(sY(0, 8)); exp_q.push_back(sAR(0));
        exp_q.push_back(sG(1, 24)); exp_q.push_back(sY(1, 8)); exp_q.push_back(sAR(1));
        exp_q.push_back(sW(1, 12));
        step(10); walk_req = 2'b10; step(1); walk_req = 2'b00;
        step(60); walk_req = 2'b10; step(1); walk_req = 2'b00;
        wait_drain("walk_set_wins", 600);

        // Phase 1 yellow programmed to 0 mid phase 0 yellow: restart, then 1-tick yellow.
        do_reset();
        exp_q.push_back(sG(0, 24)); exp_q.push_back(sY(0, 3)); exp_q.push_back(sG(0, 24));
        exp_q.push_back(sY(0, 8));  exp_q.push_back(sAR(0));   exp_q.push_back(sG(1, 24));
        exp_q.push_back(sY(1, 4));  exp_q.push_back(sAR(1));
        step(26);
        prog(3'd1, 2'd2, 4'd0);
        wait_drain("prog_yellow0", 600);

        // Phase 0 green rewritten to 2 mid green: restart uses the new value at once.
        do_reset();
        exp_q.push_back(sG(0, 19)); exp_q.push_back(sY(0, 8)); exp_q.push_back(sAR(0));
        exp_q.push_back(sG(1, 24));
        step(10);
        prog(3'd0, 2'd0, 4'd2);
        wait_drain("prog_green_restart", 400);

        // Out-of-range phase write is dropped but still restarts.
        do_reset();
        exp_q.push_back(sG(0, 24)); exp_q.push_back(sY(0, 7)); exp_q.push_back(sG(0, 24));
        exp_q.push_back(sY(0, 8));  exp_q.push_back(sAR(0));   exp_q.push_back(sG(1, 24));
        step(30);
        prog(3'd3, 2'd0, 4'd1);
        wait_drain("prog_ignored", 400);

        // Reset asserted during extension, with a walk pending for phase 0.
        do_reset();
        sensor = 2'b01;
        step(3); walk_req = 2'b01; step(1); walk_req = 2'b00;
        step(24);
        rst = 1'b0; mon_en = 1'b0; sensor = 2'b00;
        @(negedge clk);
        chk("ext_rst_green",  32'(green),  32'h1);
        chk("ext_rst_yellow", 32'(yellow), 32'h0);
        chk("ext_rst_walk",   32'(walk),   32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1; mon_en = 1'b1;
        exp_q.push_back(sG(0, 24)); exp_q.push_back(sY(0, 8)); exp_q.push_back(sAR(0));
        exp_q.push_back(sG(1, 24));
        @(negedge clk);
        chk("ext_after_green", 32'(green),     32'h1);
        chk("ext_after_walk",  32'(walk),      32'h0);
        chk("ext_after_phase", 32'(cur_phase), 32'h0);
        wait_drain("ext_rst_pend", 400);

        // 4-phase instance: only phase 3 has demand.
        mon_en = 1'b0;
        rst4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst4 = 1'b1;
        sensor4 = 4'b1000;
        step(35);
        chk("ph4_allred_phase", 32'(cur_phase4), 32'h0);
        chk("ph4_allred_red",   32'(red4),       32'hF);
        step(1);
`ifdef TRAFFIC_DEMAND_SKIP_EN
        chk("ph4_next_phase", 32'(cur_phase4), 32'h3);
        chk("ph4_next_green", 32'(green4),     32'h8);
`else
        chk("ph4_next_phase", 32'(cur_phase4), 32'h1);
        chk("ph4_next_green", 32'(green4),     32'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_phase_traffic_ctrl.md
MULTI_PHASE_TRAFFIC_CTRL -- requirements
Module: multi_phase_traffic_ctrl

Interface
REQ-001 SHALL have parameter NUM_PH, default 2, number of signal phases (legal 2..8).
REQ-002 SHALL have parameter TIME_W, default 4, width of every time value in seconds.
REQ-003 SHALL have parameter DIV_CYC, default 100_000_000, clocks per one-second tick (legal >=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port sensor  input  NUM_PH  per-phase vehicle demand, level, pre-synchronised.
REQ-007 SHALL have port walk_req  input  NUM_PH  per-phase pedestrian request pulse, pre-synchronised.
REQ-008 SHALL have port reprogram  input  1  one-cycle write strobe for timing table.
REQ-009 SHALL have port prog_phase  input  3  target phase index for write.
REQ-010 SHALL have port prog_sel  input  2  parameter: 0 base green, 1 extension, 2 yellow, 3 walk.
REQ-011 SHALL have port prog_value  input  TIME_W  value written.
REQ-012 SHALL have ports green, yellow, red, walk  output  NUM_PH each  per-phase lamps.
REQ-013 SHALL have port cur_phase  output  3  index of phase being served.

Function
REQ-014 SHALL generate a one-cycle tick every DIV_CYC clocks; divider cleared on reset and on reprogram.
REQ-015 SHALL run per-phase FSM GREEN -> (EXT) -> YELLOW -> ALL_RED -> (WALK) -> GREEN of next phase, modulo NUM_PH.
REQ-016 SHALL load timer with state duration on entry, decrement on tick, and transition on the tick where timer==1: state lasts exactly T ticks.
REQ-017 SHALL treat a programmed or default value of 0 as 1.
REQ-018 SHALL enter EXT (duration = extension) from GREEN only if sensor[cur_phase] is high on the expiring tick; at most one EXT per GREEN.
REQ-019 SHALL hold ALL_RED for exactly 1 tick.
REQ-020 SHALL latch walk_req[i] into a pending bit; WALK for cur_phase entered after ALL_RED only if its pending bit is set; bit cleared on WALK entry.
REQ-021 SHALL give precedence to set when a walk_req arrives on the cycle its pending bit clears (request kept for next cycle round).
REQ-022 SHALL drive green[cur]=1 in GREEN/EXT, yellow[cur]=1 in YELLOW, walk[cur]=1 in WALK; every other lamp bit red; exactly one of green/yellow/red high per phase.
REQ-023 SHALL, on reprogram, write table[prog_phase][prog_sel] (walk stored per phase), then restart at phase 0 GREEN with fresh timer; writes with prog_phase>=NUM_PH ignored but still restart.
REQ-024 SHALL let new table values take effect only on next state entry except when restart applies.

Reset
REQ-025 SHALL on rst low: table to defaults (green 6, ext 3, yellow 2, walk 3), pending bits 0, cur_phase 0, state GREEN, timer = base green of phase 0, divider 0.
REQ-026 SHALL drive green=1<<0, yellow=0, walk=0, red=~green during and one cycle after reset.
REQ-027 SHALL abort any in-progress state on reset with no intermediate lamp pattern.

Configuration
REQ-028 SHALL honour macro TRAFFIC_DEMAND_SKIP_EN: when defined, ALL_RED advances past any following phase with sensor low and no pending walk (round-robin search, at most NUM_PH-1 skips; if none demanding, current phase's successor is served anyway).
REQ-029 SHALL, without TRAFFIC_DEMAND_SKIP_EN, serve every phase in strict order.

Structure
REQ-030 SHALL place state enum, prog_sel codes, ALL_RED duration and default times in shared package traffic_pkg.
REQ-031 SHALL implement the divider as sub-module traffic_tick_gen (parameter DIV_CYC, outputs tick).

Verification
REQ-032 DIV_CYC=4, no inputs -> phase 0 green 24 clk, yellow 8, all-red 4, phase 1 green.
REQ-033 sensor[0]=1 during green expiry -> green lasts 9 ticks, never 12.
REQ-034 walk_req[1] pulse during phase 0 green -> walk[1] high 3 ticks after phase 1 all-red; second cycle no walk.
REQ-035 reprogram phase 1 yellow=0 mid phase 0 yellow -> immediate phase 0 green restart; phase 1 yellow lasts 1 tick.
REQ-036 rst low mid-EXT -> next cycle green=01, walk=0, pending cleared.
REQ-037 NUM_PH=4 with TRAFFIC_DEMAND_SKIP_EN, only sensor[3]=1 -> after phase 0 all-red cur_phase=3.
